// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes, sequencer state encoding and opcode helpers.
// Used by the ALU, the decoder and the ALU sequencer.
package alu_pkg;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SHR = 3'b001;
   localparam logic [2:0] ALU_SHL = 3'b010;
   localparam logic [2:0] ALU_XOR = 3'b011;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } seq_state_t;

   // Shift opcodes are run as repeated single-bit ALU passes.
   function automatic logic is_shift_op(input logic [2:0] op);
      return (op == ALU_SHR) || (op == ALU_SHL);
   endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Command/response handshake bundle between the control stage and the ALU sequencer.
interface alu_sequencer_if #(
   parameter int unsigned W   = 8,
   parameter int unsigned Ops = 3
);

   logic           req_valid;
   logic           req_ready;
   logic [Ops-1:0] req_op;
   logic [W-1:0]   req_a;
   logic [W-1:0]   req_b;
   logic           rsp_valid;
   logic           rsp_ready;
   logic [W-1:0]   rsp_data;
   logic           rsp_zero;
   logic           rsp_sign;

   // Requester side: issues commands, consumes results.
   modport master (
      output req_valid, req_op, req_a, req_b, rsp_ready,
      input  req_ready, rsp_valid, rsp_data, rsp_zero, rsp_sign
   );

   // Sequencer side.
   modport slave (
      input  req_valid, req_op, req_a, req_b, rsp_ready,
      output req_ready, rsp_valid, rsp_data, rsp_zero, rsp_sign
   );

endinterface

// File: rtl/alu.sv
// Combinational datapath ALU: add, single-bit shift right/left, xor.
// Unknown opcodes produce 0. Sign reports result bit 0.
module alu
   import alu_pkg::*;
#(
   parameter int unsigned W   = 8,
   parameter int unsigned Ops = 3
) (
   input  logic [W-1:0]   a,
   input  logic [W-1:0]   b,
   input  logic [Ops-1:0] op,
   output logic [W-1:0]   out,
   output logic           zero,
   output logic           sign
);

   // Result and flags from operands and opcode.
   always_comb begin
      out = '0;
      case (op)
         Ops'(ALU_ADD): out = a + b;
         Ops'(ALU_SHR): out = a >> 1;
         Ops'(ALU_SHL): out = a << 1;
         Ops'(ALU_XOR): out = a ^ b;
         default:       out = '0;
      endcase
      zero = (out == '0);
      sign = out[0];
   end

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle front end for the combinational ALU. Accepts one command per
// handshake, runs multi-bit shifts as one single-bit ALU pass per cycle and
// returns the result with flags on the response handshake.
module alu_sequencer
   import alu_pkg::*;
#(
   parameter int unsigned W    = 8,
   parameter int unsigned Ops  = 3,
   parameter int unsigned CntW = 4
) (
   input  logic           Clk,
   input  logic           Reset,
   alu_sequencer_if.slave bus,
   output logic [W-1:0]   alu_a,
   output logic [W-1:0]   alu_b,
   output logic [Ops-1:0] alu_op,
   input  logic [W-1:0]   alu_out,
   input  logic           alu_zero,
   input  logic           alu_sign
);

   seq_state_t     state_q, state_d;
   logic [W-1:0]   acc_q, acc_d;
   logic [W-1:0]   b_reg_q, b_reg_d;
   logic [Ops-1:0] op_reg_q, op_reg_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [W-1:0]   rsp_data_q, rsp_data_d;
   logic           rsp_zero_q, rsp_zero_d;
   logic           rsp_sign_q, rsp_sign_d;
   logic           shift_op;

   assign shift_op = is_shift_op(3'(op_reg_q));

   // State and datapath registers; synchronous reset wins over every transition.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q    <= IDLE;
         acc_q      <= '0;
         b_reg_q    <= '0;
         op_reg_q   <= '0;
         cnt_q      <= '0;
         rsp_data_q <= '0;
         rsp_zero_q <= 1'b0;
         rsp_sign_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         acc_q      <= acc_d;
         b_reg_q    <= b_reg_d;
         op_reg_q   <= op_reg_d;
         cnt_q      <= cnt_d;
         rsp_data_q <= rsp_data_d;
         rsp_zero_q <= rsp_zero_d;
         rsp_sign_q <= rsp_sign_d;
      end
   end

   // Next-state, operand capture and result capture.
   always_comb begin
      state_d    = state_q;
      acc_d      = acc_q;
      b_reg_d    = b_reg_q;
      op_reg_d   = op_reg_q;
      cnt_d      = cnt_q;
      rsp_data_d = rsp_data_q;
      rsp_zero_d = rsp_zero_q;
      rsp_sign_d = rsp_sign_q;

      case (state_q)
         IDLE: begin
            if (bus.req_valid) begin
               acc_d    = bus.req_a;
               b_reg_d  = bus.req_b;
               op_reg_d = bus.req_op;
               cnt_d    = bus.req_b[CntW-1:0];
               state_d  = EXEC;
            end
         end

         EXEC: begin
            if (!shift_op) begin
               // Single ALU pass; invalid opcodes come back as 0 from the ALU.
               rsp_data_d = alu_out;
               rsp_zero_d = alu_zero;
               rsp_sign_d = alu_sign;
               state_d    = DONE;
            end else if (cnt_q == '0) begin
               // Zero-count shift returns the operand untouched.
               rsp_data_d = acc_q;
               rsp_zero_d = (acc_q == '0);
               rsp_sign_d = acc_q[0];
               state_d    = DONE;
            end else begin
               acc_d = alu_out;
               cnt_d = cnt_q - CntW'(1);
               if (cnt_q == CntW'(1)) begin
                  rsp_data_d = alu_out;
                  rsp_zero_d = alu_zero;
                  rsp_sign_d = alu_sign;
                  state_d    = DONE;
               end
            end
         end

         DONE: begin
            if (bus.rsp_ready) begin
               state_d = IDLE;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   // Handshake outputs and ALU drive; the ALU sees zeros outside EXEC.
   always_comb begin
      bus.req_ready = (state_q == IDLE);
      bus.rsp_valid = (state_q == DONE);
      bus.rsp_data  = rsp_data_q;
      bus.rsp_zero  = rsp_zero_q;
      bus.rsp_sign  = rsp_sign_q;
      alu_a         = '0;
      alu_b         = '0;
      alu_op        = '0;
      if (state_q == EXEC) begin
         alu_a  = acc_q;
         alu_b  = b_reg_q;
         alu_op = op_reg_q;
      end
   end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer driving the real ALU.
// An arithmetic reference model predicts every response and latency; directed
// tests add hand-computed literal checks.
module tb_alu_sequencer;
   import alu_pkg::*;

   logic       Clk;
   logic       Reset;
   logic [7:0] alu_a, alu_b, alu_out;
   logic [2:0] alu_op;
   logic       alu_zero, alu_sign;

   int n_checks = 0;
   int n_fail   = 0;

   alu_sequencer_if #(.W(8), .Ops(3)) bus ();

   alu_sequencer #(.W(8), .Ops(3), .CntW(4)) dut (
      .Clk      (Clk),
      .Reset    (Reset),
      .bus      (bus),
      .alu_a    (alu_a),
      .alu_b    (alu_b),
      .alu_op   (alu_op),
      .alu_out  (alu_out),
      .alu_zero (alu_zero),
      .alu_sign (alu_sign)
   );

   alu #(.W(8), .Ops(3)) u_alu (
      .a    (alu_a),
      .b    (alu_b),
      .op   (alu_op),
      .out  (alu_out),
      .zero (alu_zero),
      .sign (alu_sign)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic timeout(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: timed out (t=%0t)", name, $time);
   endtask

   // Reference: result of a whole command and the cycles it takes to respond.
   function automatic logic [7:0] ref_result(input logic [2:0] op, input logic [7:0] a,
                                             input logic [7:0] b);
      int n;
      int t;
      n = int'(b[3:0]);
      case (op)
         ALU_ADD: t = (int'(a) + int'(b)) % 256;
         ALU_SHR: t = int'(a) >> n;
         ALU_SHL: t = (int'(a) << n) % 256;
         ALU_XOR: t = int'(a ^ b);
         default: t = 0;
      endcase
      return 8'(t);
   endfunction

   function automatic int ref_latency(input logic [2:0] op, input logic [7:0] b);
      if ((op == ALU_SHR || op == ALU_SHL) && b[3:0] != 4'd0) return int'(b[3:0]) + 1;
      return 2;
   endfunction

   // Model state.
   logic       armed   = 1'b0;
   logic       pending = 1'b0;
   int         cyc     = 0;
   int         lat     = 0;
   logic [2:0] m_op;
   logic [7:0] m_a, m_b, m_res;
   logic [7:0] held_d  = 8'h00;
   logic       held_z  = 1'b0;
   logic       held_s  = 1'b0;
   logic       vexp;
   logic [7:0] exp_acc;

   // Compare on every falling edge, then advance the model to the next rising edge.
   initial begin
      forever begin
         @(negedge Clk);
         if (armed) begin
            vexp = pending && (cyc >= lat);
            chk("req_ready", bus.req_ready, !pending);
            chk("rsp_valid", bus.rsp_valid, vexp);
            chk("rsp_data", bus.rsp_data, vexp ? m_res : held_d);
            chk("rsp_zero", bus.rsp_zero, vexp ? (m_res == 8'h00) : held_z);
            chk("rsp_sign", bus.rsp_sign, vexp ? m_res[0] : held_s);
            if (pending && !vexp) begin
               if (m_op == ALU_SHR)      exp_acc = 8'(int'(m_a) >> (cyc - 1));
               else if (m_op == ALU_SHL) exp_acc = 8'((int'(m_a) << (cyc - 1)) % 256);
               else                      exp_acc = m_a;
               chk("alu_a", alu_a, exp_acc);
               chk("alu_b", alu_b, m_b);
               chk("alu_op", alu_op, m_op);
            end else begin
               chk("alu_idle_drive", {alu_a, alu_b, alu_op}, 19'd0);
            end
         end
         if (Reset) begin
            armed   = 1'b1;
            pending = 1'b0;
            held_d  = 8'h00;
            held_z  = 1'b0;
            held_s  = 1'b0;
         end else if (armed) begin
            if (pending) begin
               if (cyc >= lat && bus.rsp_ready) begin
                  pending = 1'b0;
                  held_d  = m_res;
                  held_z  = (m_res == 8'h00);
                  held_s  = m_res[0];
               end else begin
                  cyc++;
               end
            end else if (bus.req_valid) begin
               pending = 1'b1;
               cyc     = 1;
               m_op    = bus.req_op;
               m_a     = bus.req_a;
               m_b     = bus.req_b;
               m_res   = ref_result(bus.req_op, bus.req_a, bus.req_b);
               lat     = ref_latency(bus.req_op, bus.req_b);
            end
         end
      end
   end

   logic [7:0] exec_out[$];

   // Present a command and hold it until accepted; returns just after the acceptance edge.
   task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      int n;
      n = 0;
      @(posedge Clk);
      #1;
      bus.req_valid = 1'b1;
      bus.req_op    = op;
      bus.req_a     = a;
      bus.req_b     = b;
      @(negedge Clk);
      while (!bus.req_ready && n < 50) begin
         @(negedge Clk);
         n++;
      end
      if (n >= 50) timeout("accept");
      @(posedge Clk);
      #1;
      bus.req_valid = 1'b0;
      exec_out.delete();
   endtask

   // Wait for the response and compare against hand-computed literals.
   task automatic get(input string name, input logic [7:0] d, input logic z, input logic s,
                      input int l);
      int k;
      k = 0;
      do begin
         @(negedge Clk);
         k++;
         if (!bus.rsp_valid) exec_out.push_back(alu_out);
      end while (!bus.rsp_valid && k < 40);
      if (!bus.rsp_valid) begin
         timeout({name, "_rsp"});
      end else begin
         chk({name, "_latency"}, k, l);
         chk({name, "_data"}, bus.rsp_data, d);
         chk({name, "_zero"}, bus.rsp_zero, z);
         chk({name, "_sign"}, bus.rsp_sign, s);
      end
   endtask

   initial begin
      Reset         = 1'b1;
      bus.req_valid = 1'b0;
      bus.req_op    = 3'b000;
      bus.req_a     = 8'h00;
      bus.req_b     = 8'h00;
      bus.rsp_ready = 1'b1;
      repeat (2) @(posedge Clk);
      #1;
      Reset = 1'b0;
      @(negedge Clk);
      chk("reset_req_ready", bus.req_ready, 1'b1);
      chk("reset_rsp_valid", bus.rsp_valid, 1'b0);
      chk("reset_rsp_data", bus.rsp_data, 8'h00);

      send(ALU_ADD, 8'h35, 8'h4A);
      get("add", 8'h7F, 1'b0, 1'b1, 2);

      send(ALU_ADD, 8'hFF, 8'h01);
      get("add_ovf", 8'h00, 1'b1, 1'b0, 2);

      send(ALU_SHL, 8'h81, 8'h03);
      get("shl3", 8'h08, 1'b0, 1'b0, 4);
      chk("shl3_passes", exec_out.size(), 3);
      if (exec_out.size() == 3) begin
         chk("shl3_pass0", exec_out[0], 8'h02);
         chk("shl3_pass1", exec_out[1], 8'h04);
         chk("shl3_pass2", exec_out[2], 8'h08);
      end

      send(ALU_SHR, 8'h5A, 8'h00);
      get("shr0", 8'h5A, 1'b0, 1'b0, 2);

      send(ALU_SHR, 8'hFF, 8'h0F);
      get("shr15", 8'h00, 1'b1, 1'b0, 16);

      send(3'b101, 8'h12, 8'h34);
      get("invalid", 8'h00, 1'b1, 1'b0, 2);

      // Backpressure, then a command already waiting when the response drains.
      send(ALU_XOR, 8'hF0, 8'h0F);
      bus.rsp_ready = 1'b0;
      get("xor", 8'hFF, 1'b0, 1'b1, 2);
      @(posedge Clk);
      #1;
      bus.req_valid = 1'b1;
      bus.req_op    = ALU_ADD;
      bus.req_a     = 8'h10;
      bus.req_b     = 8'h21;
      for (int i = 0; i < 5; i++) begin
         @(negedge Clk);
         chk("stall_data", bus.rsp_data, 8'hFF);
         chk("stall_req_ready", bus.req_ready, 1'b0);
      end
      @(posedge Clk);
      #1;
      bus.rsp_ready = 1'b1;
      @(posedge Clk);
      @(negedge Clk);
      chk("b2b_ready_after_handshake", bus.req_ready, 1'b1);
      @(posedge Clk);
      #1;
      bus.req_valid = 1'b0;
      get("b2b_add", 8'h31, 1'b0, 1'b1, 2);

      // Reset in the third EXEC cycle of a 7-bit shift.
      send(ALU_SHL, 8'h01, 8'h07);
      @(posedge Clk);
      #1;
      @(posedge Clk);
      #1;
      Reset = 1'b1;
      @(posedge Clk);
      #1;
      Reset = 1'b0;
      @(negedge Clk);
      chk("midrst_req_ready", bus.req_ready, 1'b1);
      chk("midrst_rsp_valid", bus.rsp_valid, 1'b0);
      chk("midrst_rsp_data", bus.rsp_data, 8'h00);

      send(ALU_ADD, 8'h02, 8'h03);
      get("post_rst_add", 8'h05, 1'b0, 1'b1, 2);

      repeat (3) @(negedge Clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Global bound so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Multi-cycle front end that drives the datapath ALU's A/B/OP inputs and consumes its out/Zero/Sign results.
- Accepts one command per valid/ready handshake and returns one result with flags on a response handshake.
- Shift commands with a shift count are executed as repeated single-bit ALU shifts, one ALU pass per cycle.
- Sits between the CPU control/decode stage and the combinational ALU.

Parameters:
- W, 8, data width; must match the ALU W.
- Ops, 3, opcode width; must match the ALU Ops.
- CntW, 4, shift-count width, taken from req_b[CntW-1:0]; counts 0..15.

Ports:
- Clk  in  1  clock, rising edge.
- Reset  in  1  synchronous, active-high.
- req_valid  in  1  command valid.
- req_ready  out  1  sequencer can accept a command.
- req_op  in  Ops  000 add, 001 shr, 010 shl, 011 xor; others are invalid.
- req_a  in  W  operand A.
- req_b  in  W  operand B; for shifts, bits [CntW-1:0] are the shift count.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  consumer takes the result.
- rsp_data  out  W  result.
- rsp_zero  out  1  result == 0.
- rsp_sign  out  1  result bit 0; same definition as the ALU Sign flag.
- alu_a  out  W  to ALU A.
- alu_b  out  W  to ALU B.
- alu_op  out  Ops  to ALU OP.
- alu_out  in  W  from ALU out.
- alu_zero  in  1  from ALU Zero.
- alu_sign  in  1  from ALU Sign.

Behaviour:
- Reset (on the Clk edge with Reset=1):
  - state <= IDLE; acc, b_reg, op_reg, cnt, rsp_data, rsp_zero, rsp_sign all <= 0.
  - Any in-flight command is dropped.
  - After that edge: req_ready=1, rsp_valid=0.
- Outputs by state:
  - req_ready = (state==IDLE).
  - rsp_valid = (state==DONE).
- ALU drive:
  - In EXEC: alu_a=acc, alu_b=b_reg, alu_op=op_reg.
  - In IDLE and DONE: alu_a=0, alu_b=0, alu_op=000.
- IDLE:
  - On req_valid & req_ready: acc<=req_a, b_reg<=req_b, op_reg<=req_op, cnt<=req_b[CntW-1:0]; go to EXEC.
- EXEC, add/xor/invalid op (single pass):
  - rsp_data<=alu_out, rsp_zero<=alu_zero, rsp_sign<=alu_sign; go to DONE.
  - Invalid ops therefore return 0 with zero=1, sign=0, because the ALU default output is 0.
- EXEC, shr/shl:
  - cnt==0: rsp_data<=acc, rsp_zero<=(acc==0), rsp_sign<=acc[0]; go to DONE. Takes one EXEC cycle and the ALU result is ignored.
  - cnt>=1: acc<=alu_out, cnt<=cnt-1.
  - When cnt==1, also capture rsp_data<=alu_out, rsp_zero<=alu_zero, rsp_sign<=alu_sign and go to DONE.
  - A shift by n>=1 occupies n EXEC cycles. Counts >= W give 0.
- DONE:
  - Hold rsp_data/rsp_zero/rsp_sign stable while rsp_valid=1 and rsp_ready=0; no limit on the stall.
  - On rsp_ready: go to IDLE.
  - No overlap: a new request is accepted no earlier than the cycle after the response handshake.
- Latency, counted from the acceptance edge to the first cycle rsp_valid=1:
  - add/xor/invalid and shift count 0: 2 cycles.
  - shift by n>=1: n+1 cycles.
- Arithmetic: add is modulo 2^W; carry is discarded.
- While in EXEC/DONE, req_valid is ignored; the requester must hold the command until req_ready.
- Reset asserted in any state has priority over all transitions, including the DONE handshake.

Decomposition:
- Package alu_pkg:
  - Opcode localparams ALU_ADD=3'b000, ALU_SHR=3'b001, ALU_SHL=3'b010, ALU_XOR=3'b011.
  - State enum {IDLE, EXEC, DONE}, 2 bits.
  - Shared by this block, the ALU, and the decoder.
- No sub-module. The ALU stays external and is connected at the CPU top level. The bench instantiates the real ALU beside this block.

Test Plan:
- Add: A=0x35, B=0x4A, op=000 -> rsp_data=0x7F, zero=0, sign=1; rsp_valid exactly 2 cycles after acceptance.
- Add overflow: A=0xFF, B=0x01 -> rsp_data=0x00, zero=1, sign=0.
- Shift left: A=0x81, B=0x03, op=010 -> alu_out sequence 0x02, 0x04, 0x08 on consecutive EXEC cycles; rsp_data=0x08, sign=0; rsp_valid 4 cycles after acceptance.
- Shift right, count 0: A=0x5A, B=0x00, op=001 -> rsp_data=0x5A, zero=0, sign=0, latency 2. Separately, shr A=0xFF, B=0x0F -> rsp_data=0x00, zero=1.
- Backpressure and back-to-back:
  - xor A=0xF0, B=0x0F -> 0xFF.
  - Hold rsp_ready=0 for 5 cycles -> rsp_data stays 0xFF and req_ready stays 0.
  - Release rsp_ready with the next add already valid -> accepted the cycle after the handshake.
- Reset mid-shift: shl A=0x01, B=0x07; assert Reset at the 3rd EXEC cycle -> next cycle req_ready=1, rsp_valid=0, rsp_data=0x00. A following add 0x02+0x03 returns 0x05.
